// File: rtl/spi_pkg.sv
// Shared types for the SPI responder: FSM state, SCLK edge strobes, width limit.
package spi_pkg;

    localparam int MAX_DATA_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } resp_state_e;

    typedef struct packed {
        logic lead;
        logic trail;
    } edge_strobe_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the asynchronous SPI pins into clockIn and derives registered
// SCLK leading/trailing and SS_n falling/rising strobes.
module spi_pin_sync
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clockIn,
    input  logic         reset,
    input  logic         polarity,
    input  logic         sclk,
    input  logic         ss_n,
    input  logic         mosi,
    output logic         mosi_s,
    output edge_strobe_t sclk_edge,
    output logic         ss_fall,
    output logic         ss_rise
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] ss_n_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_prev_q;
    logic                   ss_n_prev_q;
    logic                   mosi_s_q;
    edge_strobe_t           sclk_edge_q;
    logic                   ss_fall_q;
    logic                   ss_rise_q;
    logic                   sclk_s;
    logic                   ss_n_s;

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign ss_n_s = ss_n_q[SYNC_STAGES-1];

    // Strobes are registered once more so mosi_s stays aligned with them.
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            sclk_q      <= {SYNC_STAGES{polarity}};
            ss_n_q      <= '1;
            mosi_q      <= '0;
            sclk_prev_q <= polarity;
            ss_n_prev_q <= 1'b1;
            mosi_s_q    <= 1'b0;
            sclk_edge_q <= '0;
            ss_fall_q   <= 1'b0;
            ss_rise_q   <= 1'b0;
        end else begin
            sclk_q            <= {sclk_q[SYNC_STAGES-2:0], sclk};
            ss_n_q            <= {ss_n_q[SYNC_STAGES-2:0], ss_n};
            mosi_q            <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q       <= sclk_s;
            ss_n_prev_q       <= ss_n_s;
            mosi_s_q          <= mosi_q[SYNC_STAGES-1];
            sclk_edge_q.lead  <= (sclk_prev_q == polarity) && (sclk_s != polarity);
            sclk_edge_q.trail <= (sclk_prev_q != polarity) && (sclk_s == polarity);
            ss_fall_q         <= ss_n_prev_q && !ss_n_s;
            ss_rise_q         <= !ss_n_prev_q && ss_n_s;
        end
    end

    assign mosi_s    = mosi_s_q;
    assign sclk_edge = sclk_edge_q;
    assign ss_fall   = ss_fall_q;
    assign ss_rise   = ss_rise_q;

endmodule

// File: rtl/spi_responder_core.sv
// SPI responder shifter: pin-side SCLK/SS_n/MOSI/MISO to bus-side valid/ready words.
// Optional macro SPI_RESPONDER_LSB_FIRST_EN adds the lsb_first port (LSB-first bit order).
module spi_responder_core
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    SYNC_STAGES  = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD = '0
) (
    input  logic                  clockIn,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  polarity,
    input  logic                  phase,
`ifdef SPI_RESPONDER_LSB_FIRST_EN
    input  logic                  lsb_first,
`endif
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  underrun,
    output logic                  overrun,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    resp_state_e           state_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  first_q;
    logic                  reload_q;
    logic [CNT_W-1:0]      bit_count_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic [DATA_WIDTH-2:0] rx_shift_q;
    logic                  rx_valid_q;
    logic                  tx_ready_q;
    logic                  underrun_q;
    logic                  overrun_q;
    logic                  frame_error_q;
    logic                  miso_oe_q;
`ifdef SPI_RESPONDER_LSB_FIRST_EN
    logic                  lsb_q;
`endif

    logic                  pol_eff;
    logic                  mosi_s;
    logic                  ss_fall;
    logic                  ss_rise;
    edge_strobe_t          sclk_edge;
    logic                  sample_stb;
    logic                  shift_stb;
    logic                  tx_bit;
    logic [DATA_WIDTH-1:0] tx_next_d;
    logic [DATA_WIDTH-1:0] tx_shifted_d;
    logic [DATA_WIDTH-1:0] rx_word_d;
    logic [DATA_WIDTH-2:0] rx_shift_d;

    // Live polarity while idle so the edge detector tracks the bus before a frame.
    assign pol_eff = (state_q == IDLE) ? polarity : cpol_q;

    spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_pin_sync (
        .clockIn  (clockIn),
        .reset    (reset),
        .polarity (pol_eff),
        .sclk     (sclk),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .mosi_s   (mosi_s),
        .sclk_edge(sclk_edge),
        .ss_fall  (ss_fall),
        .ss_rise  (ss_rise)
    );

    assign sample_stb = cpha_q ? sclk_edge.trail : sclk_edge.lead;
    assign shift_stb  = cpha_q ? sclk_edge.lead  : sclk_edge.trail;
    assign tx_next_d  = tx_valid ? tx_data : TX_IDLE_WORD;

    always_comb begin
`ifdef SPI_RESPONDER_LSB_FIRST_EN
        if (lsb_q) begin
            rx_word_d    = {mosi_s, rx_shift_q};
            rx_shift_d   = rx_word_d[DATA_WIDTH-1:1];
            tx_shifted_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
            tx_bit       = tx_shift_q[0];
        end else begin
            rx_word_d    = {rx_shift_q, mosi_s};
            rx_shift_d   = rx_word_d[DATA_WIDTH-2:0];
            tx_shifted_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            tx_bit       = tx_shift_q[DATA_WIDTH-1];
        end
`else
        rx_word_d    = {rx_shift_q, mosi_s};
        rx_shift_d   = rx_word_d[DATA_WIDTH-2:0];
        tx_shifted_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        tx_bit       = tx_shift_q[DATA_WIDTH-1];
`endif
    end

    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            first_q       <= 1'b0;
            reload_q      <= 1'b0;
            bit_count_q   <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_ready_q    <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
            miso_oe_q     <= 1'b0;
`ifdef SPI_RESPONDER_LSB_FIRST_EN
            lsb_q         <= 1'b0;
`endif
        end else begin
            tx_ready_q    <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
            if (rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cpol_q    <= polarity;
                    cpha_q    <= phase;
`ifdef SPI_RESPONDER_LSB_FIRST_EN
                    lsb_q     <= lsb_first;
`endif
                    miso_oe_q <= 1'b0;
                    if (enable && ss_fall) begin
                        tx_shift_q  <= tx_next_d;
                        tx_ready_q  <= tx_valid;
                        underrun_q  <= !tx_valid;
                        bit_count_q <= '0;
                        reload_q    <= 1'b0;
                        first_q     <= phase;
                        miso_oe_q   <= 1'b1;
                        state_q     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (!enable || ss_rise) begin
                        // A disable aborts silently; only a deselect mid-word is an error.
                        frame_error_q <= enable && (bit_count_q != '0);
                        bit_count_q   <= '0;
                        reload_q      <= 1'b0;
                        first_q       <= 1'b0;
                        miso_oe_q     <= 1'b0;
                        state_q       <= IDLE;
                    end else if (sample_stb) begin
                        rx_shift_q <= rx_shift_d;
                        if (bit_count_q == LAST_BIT) begin
                            rx_data_q   <= rx_word_d;
                            rx_valid_q  <= 1'b1;
                            overrun_q   <= rx_valid_q && !rx_ready;
                            bit_count_q <= '0;
                            reload_q    <= 1'b1;
                        end else begin
                            bit_count_q <= bit_count_q + CNT_W'(1);
                        end
                    end else if (shift_stb) begin
                        // CPHA=1: the first leading edge only presents the already-loaded MSB.
                        if (first_q) begin
                            first_q <= 1'b0;
                        end else if (reload_q) begin
                            tx_shift_q <= tx_next_d;
                            tx_ready_q <= tx_valid;
                            underrun_q <= !tx_valid;
                            reload_q   <= 1'b0;
                        end else begin
                            tx_shift_q <= tx_shifted_d;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso        = miso_oe_q & tx_bit;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign underrun    = underrun_q;
    assign overrun     = overrun_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_responder_core.sv
// Directed bench: an SPI master model drives the pins, a scoreboard tracks
// expected RX words and event counts, and a per-cycle monitor checks outputs.
module tb_spi_responder_core;

    localparam int DW   = 32;
    localparam int HALF = 8;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          polarity;
    logic          phase;
    logic          sclk;
    logic          ss_n;
    logic          mosi;
    logic          miso;
    logic          miso_oe;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          underrun;
    logic          overrun;
    logic          frame_error;
    logic          busy;
`ifdef SPI_RESPONDER_LSB_FIRST_EN
    logic          lsb_first;
    initial lsb_first = 1'b0;
`endif

    spi_responder_core #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (2),
        .TX_IDLE_WORD(32'h0)
    ) dut (
        .clockIn    (clk),
        .reset      (rst_n),
        .enable     (enable),
        .polarity   (polarity),
        .phase      (phase),
`ifdef SPI_RESPONDER_LSB_FIRST_EN
        .lsb_first  (lsb_first),
`endif
        .sclk       (sclk),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .underrun   (underrun),
        .overrun    (overrun),
        .frame_error(frame_error),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int c_txr  = 0, c_und = 0, c_ovr = 0, c_fe = 0, c_rxw = 0;
    int b_txr, b_und, b_ovr, b_fe, b_rxw;

    logic [DW-1:0] txq[$];
    logic [DW-1:0] exp_rx[$];
    logic [DW-1:0] mw[0:1];
    logic [DW-1:0] rw[0:1];
    logic          prev_vld = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        b_txr = c_txr; b_und = c_und; b_ovr = c_ovr; b_fe = c_fe; b_rxw = c_rxw;
    endtask

    task automatic setup_mode(input logic pol, input logic pha);
        polarity = pol;
        phase    = pha;
        sclk     = pol;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        wait_clk(6);
    endtask

    // SPI master, MSB first; records MISO into rw[] and queues each full MOSI word.
    task automatic master_frame(input int nbits, input bit end_frame);
        int w;
        int k;
        ss_n = 1'b0;
        wait_clk(2 * HALF);
        for (int i = 0; i < nbits; i++) begin
            w = i / DW;
            k = DW - 1 - (i % DW);
            if (!phase) begin
                mosi = mw[w][k];
                wait_clk(HALF);
                sclk = ~polarity;
                rw[w][k] = miso;
                if (k == 0) exp_rx.push_back(mw[w]);
                wait_clk(HALF);
                sclk = polarity;
            end else begin
                sclk = ~polarity;
                mosi = mw[w][k];
                wait_clk(HALF);
                sclk = polarity;
                rw[w][k] = miso;
                if (k == 0) exp_rx.push_back(mw[w]);
                wait_clk(HALF);
            end
        end
        if (!phase) wait_clk(HALF);
        if (end_frame) begin
            ss_n = 1'b1;
            wait_clk(2 * HALF);
        end
    endtask

    // TX producer: presents the queue head, retires it on tx_ready.
    initial begin
        tx_valid = 1'b0;
        tx_data  = '0;
        forever begin
            @(negedge clk);
            if (tx_ready && txq.size() > 0) void'(txq.pop_front());
            tx_valid = (txq.size() > 0);
            tx_data  = tx_valid ? txq[0] : '0;
        end
    end

    // Per-cycle monitor against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("busy_vs_oe", busy, miso_oe);
                if (!miso_oe) check("miso_when_off", miso, 0);
                if (tx_ready) begin
                    c_txr++;
                    check("txr_not_und", underrun, 0);
                end
                if (underrun) c_und++;
                if (overrun) c_ovr++;
                if (frame_error) begin
                    c_fe++;
                    check("oe_at_ferr", miso_oe, 0);
                end
                if ((rx_valid && !prev_vld) || overrun) begin
                    c_rxw++;
                    check("rx_word_expected", exp_rx.size() > 0, 1);
                    if (exp_rx.size() > 0) check("rx_word", rx_data, exp_rx.pop_front());
                end
            end
            prev_vld = rx_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        polarity = 1'b0;
        phase    = 1'b0;
        sclk     = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        rx_ready = 1'b1;
        wait_clk(4);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_underrun", underrun, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_error", frame_error, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_clk(4);

        // Mode 0, single word, consumer stalled so rx_valid is held.
        rx_ready = 1'b0;
        txq.push_back(32'hA5A5_5A5A);
        setup_mode(1'b0, 1'b0);
        mark();
        mw[0] = 32'h1234_5678;
        master_frame(32, 1);
        check("t1_master_rx", rw[0], 32'hA5A5_5A5A);
        check("t1_rx_data", rx_data, 32'h1234_5678);
        check("t1_rx_valid", rx_valid, 1);
        check("t1_tx_ready_cnt", c_txr - b_txr, 1);
        // the final trailing edge preloads a next word; none is queued
        check("t1_underrun_cnt", c_und - b_und, 1);
        check("t1_overrun_cnt", c_ovr - b_ovr, 0);
        rx_ready = 1'b1;
        wait_clk(2);
        check("t1_rx_valid_clr", rx_valid, 0);

        // Mode 3, two words back to back.
        txq.push_back(32'h0F1E_2D3C);
        txq.push_back(32'hC3D2_E1F0);
        setup_mode(1'b1, 1'b1);
        mark();
        mw[0] = 32'hDEAD_BEEF;
        mw[1] = 32'hCAFE_F00D;
        master_frame(64, 1);
        check("t2_master_rx0", rw[0], 32'h0F1E_2D3C);
        check("t2_master_rx1", rw[1], 32'hC3D2_E1F0);
        check("t2_rx_data", rx_data, 32'hCAFE_F00D);
        check("t2_rx_words", c_rxw - b_rxw, 2);
        check("t2_tx_ready_cnt", c_txr - b_txr, 2);
        check("t2_underrun_cnt", c_und - b_und, 0);
        check("t2_overrun_cnt", c_ovr - b_ovr, 0);

        // Mode 1, no TX data: idle word goes out.
        setup_mode(1'b0, 1'b1);
        mark();
        mw[0] = 32'h0F0F_3C3C;
        master_frame(32, 1);
        check("t3_master_rx", rw[0], 32'h0000_0000);
        check("t3_rx_data", rx_data, 32'h0F0F_3C3C);
        check("t3_underrun_cnt", c_und - b_und, 1);
        check("t3_tx_ready_cnt", c_txr - b_txr, 0);

        // Mode 2, consumer stalled across two words: overrun on the second.
        rx_ready = 1'b0;
        txq.push_back(32'h0123_4567);
        txq.push_back(32'h89AB_CDEF);
        setup_mode(1'b1, 1'b0);
        mark();
        mw[0] = 32'h8000_0001;
        mw[1] = 32'h7FFF_FFFE;
        master_frame(64, 1);
        check("t4_master_rx0", rw[0], 32'h0123_4567);
        check("t4_master_rx1", rw[1], 32'h89AB_CDEF);
        check("t4_rx_data", rx_data, 32'h7FFF_FFFE);
        check("t4_rx_valid", rx_valid, 1);
        check("t4_overrun_cnt", c_ovr - b_ovr, 1);
        check("t4_tx_ready_cnt", c_txr - b_txr, 2);
        check("t4_underrun_cnt", c_und - b_und, 1);
        rx_ready = 1'b1;
        wait_clk(2);
        check("t4_rx_valid_clr", rx_valid, 0);

        // Deselect after 13 bits, then a clean frame.
        txq.push_back(32'h5A5A_0F0F);
        setup_mode(1'b0, 1'b0);
        mark();
        mw[0] = 32'hFFFF_0000;
        master_frame(13, 0);
        ss_n = 1'b1;
        wait_clk(2 * HALF);
        check("t5_ferr_cnt", c_fe - b_fe, 1);
        check("t5_rx_valid", rx_valid, 0);
        check("t5_rx_words", c_rxw - b_rxw, 0);
        check("t5_miso_oe", miso_oe, 0);
        txq.push_back(32'h1357_9BDF);
        wait_clk(4);
        mw[0] = 32'h5555_AAAA;
        master_frame(32, 1);
        check("t5_master_rx", rw[0], 32'h1357_9BDF);
        check("t5_rx_data", rx_data, 32'h5555_AAAA);
        check("t5_ferr_cnt2", c_fe - b_fe, 1);

        // Disable after 8 bits: back to idle within a cycle, no events.
        txq.push_back(32'h2468_ACE0);
        setup_mode(1'b1, 1'b0);
        mark();
        mw[0] = 32'hFEDC_BA98;
        master_frame(8, 0);
        enable = 1'b0;
        wait_clk(1);
        check("t6_busy", busy, 0);
        check("t6_miso_oe", miso_oe, 0);
        check("t6_miso", miso, 0);
        ss_n = 1'b1;
        wait_clk(2 * HALF);
        check("t6_ferr_cnt", c_fe - b_fe, 0);
        check("t6_rx_words", c_rxw - b_rxw, 0);
        check("t6_rx_valid", rx_valid, 0);
        enable = 1'b1;

        // Reset mid-word.
        txq.push_back(32'h1111_1111);
        setup_mode(1'b0, 1'b1);
        mark();
        mw[0] = 32'h0BAD_F00D;
        master_frame(10, 0);
        rst_n = 1'b0;
        #1;
        check("t7_miso", miso, 0);
        check("t7_miso_oe", miso_oe, 0);
        check("t7_busy", busy, 0);
        check("t7_rx_data", rx_data, 0);
        check("t7_rx_valid", rx_valid, 0);
        check("t7_pulses", {tx_ready, underrun, overrun, frame_error}, 0);
        ss_n = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(2 * HALF);
        check("t7_busy_after", busy, 0);
        check("t7_ferr_cnt", c_fe - b_fe, 0);
        check("t7_rx_words", c_rxw - b_rxw, 0);
        check("all_rx_delivered", exp_rx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
